// File: rtl/slc3_control_fsm.sv
// slc3_control_fsm: fetch/decode/execute sequencer for the SLC-3 CPU.
// Drives every datapath load, bus gate and mux select, plus the memory strobes.
// Memory accesses last exactly MEM_WAIT cycles (legal range 1..15).
// Optional feature macro: SLC3_PAUSE_EN. When it is defined, opcode 1101 is
// PAUSE (LED load followed by a Continue press-and-release). When it is not
// defined, 1101 executes as a NOP and LD_LED is tied low.
module slc3_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, FETCH1, FETCH2, FETCH3, DECODE,
        EX_ADD, EX_AND, EX_NOT,
        BR0, BR1, EX_JMP,
        JSR0, JSR1, JSRR,
        LDR0, LDR1, LDR2,
        STR0, STR1, STR2
`ifdef SLC3_PAUSE_EN
        , PAUSE1, PAUSE2, PAUSE3
`endif
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       mem_done;

`ifndef SLC3_PAUSE_EN
    // Continue only matters to the PAUSE states, which are absent in this build.
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    assign mem_done = (wait_cnt == WAIT_LAST);

    // State register and wait counter. The counter is cleared on every cycle
    // that does not stay inside a memory-wait state, so it is always zero on
    // entry to FETCH2, LDR1 and STR2.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                HALTED: if (Run) state <= FETCH1;
                FETCH1: state <= FETCH2;
                FETCH2: begin
                    if (mem_done) state <= FETCH3;
                    else          wait_cnt <= wait_cnt + 4'd1;
                end
                FETCH3: state <= DECODE;
                DECODE: begin
                    case (Opcode)
                        4'b0001: state <= EX_ADD;
                        4'b0101: state <= EX_AND;
                        4'b1001: state <= EX_NOT;
                        4'b0000: state <= BR0;
                        4'b1100: state <= EX_JMP;
                        4'b0100: state <= JSR0;
                        4'b0110: state <= LDR0;
                        4'b0111: state <= STR0;
`ifdef SLC3_PAUSE_EN
                        4'b1101: state <= PAUSE1;
`endif
                        default: state <= FETCH1;
                    endcase
                end
                BR0:  state <= BEN ? BR1 : FETCH1;
                JSR0: state <= IR_11 ? JSR1 : JSRR;
                LDR0: state <= LDR1;
                LDR1: begin
                    if (mem_done) state <= LDR2;
                    else          wait_cnt <= wait_cnt + 4'd1;
                end
                STR0: state <= STR1;
                STR1: state <= STR2;
                STR2: begin
                    if (mem_done) state <= FETCH1;
                    else          wait_cnt <= wait_cnt + 4'd1;
                end
`ifdef SLC3_PAUSE_EN
                PAUSE1: state <= PAUSE2;
                PAUSE2: if (Continue)  state <= PAUSE3;
                PAUSE3: if (!Continue) state <= FETCH1;
`endif
                EX_ADD, EX_AND, EX_NOT, BR1, EX_JMP, JSR1, JSRR, LDR2:
                    state <= FETCH1;
                default: state <= HALTED;
            endcase
        end
    end

    // Moore output decode: every control line defaults low, and each state
    // raises only the lines it needs.
    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        case (state)
            FETCH1: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00;
            end
            FETCH2, LDR1: begin
                Mem_OE = 1'b1;
                LD_MDR = mem_done;
            end
            FETCH3: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
            end
            DECODE: LD_BEN = 1'b1;
            EX_ADD, EX_AND: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                SR1MUX = 1'b1; SR2MUX = IR_5;
                ALUK = (state == EX_AND) ? 2'b01 : 2'b00;
            end
            EX_NOT: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                SR1MUX = 1'b1; ALUK = 2'b10;
            end
            BR1: begin
                LD_PC = 1'b1; PCMUX = 2'b10; ADDR1MUX = 1'b0; ADDR2MUX = 2'b10;
            end
            EX_JMP, JSRR: begin
                LD_PC = 1'b1; PCMUX = 2'b10; ADDR1MUX = 1'b1; ADDR2MUX = 2'b00;
                SR1MUX = 1'b1;
            end
            JSR0: begin
                // R7 <- PC happens here, before the PC update in JSR1/JSRR.
                GatePC = 1'b1; LD_REG = 1'b1; DRMUX = 1'b1;
            end
            JSR1: begin
                LD_PC = 1'b1; PCMUX = 2'b10; ADDR1MUX = 1'b0; ADDR2MUX = 2'b11;
            end
            LDR0, STR0: begin
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
                ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; SR1MUX = 1'b1;
            end
            LDR2: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            STR1: begin
                GateALU = 1'b1; LD_MDR = 1'b1; ALUK = 2'b11; SR1MUX = 1'b0;
            end
            STR2: Mem_WE = 1'b1;
`ifdef SLC3_PAUSE_EN
            PAUSE1: LD_LED = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_control_fsm.sv
// tb_slc3_control_fsm: randomized instruction stream against a per-instruction
// cycle-table model. Two instances (MEM_WAIT = 2 and 3) share inputs; each
// phase resets both and checks one of them.
module tb_slc3_control_fsm;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic oe, we;
    } ctl_t;

    logic clk = 1'b0;
    logic reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;

    logic LD_MAR_a, LD_MDR_a, LD_IR_a, LD_BEN_a, LD_CC_a, LD_REG_a, LD_PC_a, LD_LED_a;
    logic GatePC_a, GateMDR_a, GateALU_a, GateMARMUX_a, DRMUX_a, SR1MUX_a, SR2MUX_a, ADDR1MUX_a;
    logic [1:0] PCMUX_a, ADDR2MUX_a, ALUK_a;
    logic Mem_OE_a, Mem_WE_a;
    logic LD_MAR_b, LD_MDR_b, LD_IR_b, LD_BEN_b, LD_CC_b, LD_REG_b, LD_PC_b, LD_LED_b;
    logic GatePC_b, GateMDR_b, GateALU_b, GateMARMUX_b, DRMUX_b, SR1MUX_b, SR2MUX_b, ADDR1MUX_b;
    logic [1:0] PCMUX_b, ADDR2MUX_b, ALUK_b;
    logic Mem_OE_b, Mem_WE_b;

    ctl_t obs_a, obs_b, obs;
    int   sel;
    int   n_cmp = 0, n_bad = 0;
    ctl_t exp_q[$];
    logic cont_q[$];

    always #5 clk = ~clk;

    slc3_control_fsm #(.MEM_WAIT(2)) dut_a (
        .clk(clk), .reset(reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR_a), .LD_MDR(LD_MDR_a), .LD_IR(LD_IR_a), .LD_BEN(LD_BEN_a),
        .LD_CC(LD_CC_a), .LD_REG(LD_REG_a), .LD_PC(LD_PC_a), .LD_LED(LD_LED_a),
        .GatePC(GatePC_a), .GateMDR(GateMDR_a), .GateALU(GateALU_a), .GateMARMUX(GateMARMUX_a),
        .PCMUX(PCMUX_a), .DRMUX(DRMUX_a), .SR1MUX(SR1MUX_a), .SR2MUX(SR2MUX_a),
        .ADDR1MUX(ADDR1MUX_a), .ADDR2MUX(ADDR2MUX_a), .ALUK(ALUK_a),
        .Mem_OE(Mem_OE_a), .Mem_WE(Mem_WE_a)
    );

    slc3_control_fsm #(.MEM_WAIT(3)) dut_b (
        .clk(clk), .reset(reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR_b), .LD_MDR(LD_MDR_b), .LD_IR(LD_IR_b), .LD_BEN(LD_BEN_b),
        .LD_CC(LD_CC_b), .LD_REG(LD_REG_b), .LD_PC(LD_PC_b), .LD_LED(LD_LED_b),
        .GatePC(GatePC_b), .GateMDR(GateMDR_b), .GateALU(GateALU_b), .GateMARMUX(GateMARMUX_b),
        .PCMUX(PCMUX_b), .DRMUX(DRMUX_b), .SR1MUX(SR1MUX_b), .SR2MUX(SR2MUX_b),
        .ADDR1MUX(ADDR1MUX_b), .ADDR2MUX(ADDR2MUX_b), .ALUK(ALUK_b),
        .Mem_OE(Mem_OE_b), .Mem_WE(Mem_WE_b)
    );

    assign obs_a = {LD_MAR_a, LD_MDR_a, LD_IR_a, LD_BEN_a, LD_CC_a, LD_REG_a, LD_PC_a, LD_LED_a,
                    GatePC_a, GateMDR_a, GateALU_a, GateMARMUX_a, PCMUX_a, DRMUX_a, SR1MUX_a,
                    SR2MUX_a, ADDR1MUX_a, ADDR2MUX_a, ALUK_a, Mem_OE_a, Mem_WE_a};
    assign obs_b = {LD_MAR_b, LD_MDR_b, LD_IR_b, LD_BEN_b, LD_CC_b, LD_REG_b, LD_PC_b, LD_LED_b,
                    GatePC_b, GateMDR_b, GateALU_b, GateMARMUX_b, PCMUX_b, DRMUX_b, SR1MUX_b,
                    SR2MUX_b, ADDR1MUX_b, ADDR2MUX_b, ALUK_b, Mem_OE_b, Mem_WE_b};
    assign obs = (sel != 0) ? obs_b : obs_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic push(input ctl_t c, input logic cont);
        exp_q.push_back(c);
        cont_q.push_back(cont);
    endtask

    // Reference: the control word of every cycle of one instruction, from
    // FETCH1 to its last execute cycle, plus the Continue value to drive.
    task automatic build(input logic [3:0] op, input logic ir5, input logic ben,
                         input logic ir11, input int mw, input int a, input int m);
        ctl_t c;
        exp_q.delete(); cont_q.delete();
        c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push(c, 1'($urandom));
        for (int i = 0; i < mw; i++) begin
            c = '0; c.oe = 1; c.ld_mdr = (i == mw - 1); push(c, 1'($urandom));
        end
        c = '0; c.gate_mdr = 1; c.ld_ir = 1; push(c, 1'($urandom));
        c = '0; c.ld_ben = 1; push(c, 1'($urandom));
        case (op)
            4'b0001, 4'b0101: begin
                c = '0; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1;
                c.sr2mux = ir5; c.aluk = (op == 4'b0101) ? 2'd1 : 2'd0; push(c, 1'($urandom));
            end
            4'b1001: begin
                c = '0; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1;
                c.aluk = 2'd2; push(c, 1'($urandom));
            end
            4'b0000: begin
                c = '0; push(c, 1'($urandom));
                if (ben) begin
                    c = '0; c.ld_pc = 1; c.pcmux = 2'd2; c.addr2mux = 2'd2; push(c, 1'($urandom));
                end
            end
            4'b1100: begin
                c = '0; c.ld_pc = 1; c.pcmux = 2'd2; c.addr1mux = 1; c.sr1mux = 1;
                push(c, 1'($urandom));
            end
            4'b0100: begin
                c = '0; c.gate_pc = 1; c.ld_reg = 1; c.drmux = 1; push(c, 1'($urandom));
                c = '0; c.ld_pc = 1; c.pcmux = 2'd2;
                if (ir11) c.addr2mux = 2'd3;
                else begin c.addr1mux = 1; c.sr1mux = 1; end
                push(c, 1'($urandom));
            end
            4'b0110, 4'b0111: begin
                c = '0; c.gate_marmux = 1; c.ld_mar = 1; c.addr1mux = 1; c.addr2mux = 2'd1;
                c.sr1mux = 1; push(c, 1'($urandom));
                if (op == 4'b0110) begin
                    for (int i = 0; i < mw; i++) begin
                        c = '0; c.oe = 1; c.ld_mdr = (i == mw - 1); push(c, 1'($urandom));
                    end
                    c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c, 1'($urandom));
                end else begin
                    c = '0; c.gate_alu = 1; c.ld_mdr = 1; c.aluk = 2'd3; push(c, 1'($urandom));
                    for (int i = 0; i < mw; i++) begin
                        c = '0; c.we = 1; push(c, 1'($urandom));
                    end
                end
            end
`ifdef SLC3_PAUSE_EN
            4'b1101: begin
                c = '0; c.ld_led = 1; push(c, 1'($urandom));
                c = '0;
                for (int i = 0; i < a; i++) push(c, 1'b0);
                for (int i = 0; i < m; i++) push(c, 1'b1);
                push(c, 1'b0);
            end
`endif
            default: ;
        endcase
    endtask

    // Drive one instruction cycle by cycle. abort_at >= 0 raises reset right
    // after that cycle is checked, then verifies the return to HALTED.
    task automatic run_instr(input int idx, input logic [3:0] op, input logic ir5,
                             input logic ben, input logic ir11, input int a, input int m,
                             input int abort_at);
        int mw;
        mw = (sel != 0) ? 3 : 2;
        build(op, ir5, ben, ir11, mw, a, m);
        for (int t = 0; t < exp_q.size(); t++) begin
            @(negedge clk);
            chk($sformatf("i%0d op%b cyc%0d", idx, op, t), 32'(obs), 32'(exp_q[t]));
            if (t == 0) begin
                Opcode = op; IR_5 = ir5; BEN = ben; IR_11 = ir11;
            end
            Continue = cont_q[t];
            Run = 1'($urandom);
            if (t == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk($sformatf("i%0d abort_halted", idx), 32'(obs), 32'd0);
                reset = 1'b0; Run = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk($sformatf("i%0d abort_idle%0d", idx, k), 32'(obs), 32'd0);
                end
                Run = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'd0;
        IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; sel = 0;
        for (int ph = 0; ph < 2; ph++) begin
            sel = ph;
            reset = 1'b1; Run = 1'b0; Continue = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk($sformatf("p%0d reset%0d", ph, k), 32'(obs), 32'd0);
            end
            reset = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk($sformatf("p%0d halted%0d", ph, k), 32'(obs), 32'd0);
            end
            Run = 1'b1;
            // Directed opening sequence, then a random instruction stream.
            run_instr(0, 4'b0001, 1'b1, 1'b0, 1'b0, 0, 1, -1);
            run_instr(1, 4'b0101, 1'b0, 1'b0, 1'b0, 0, 1, -1);
            run_instr(2, 4'b1001, 1'b1, 1'b0, 1'b0, 0, 1, -1);
            run_instr(3, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1, -1);
            run_instr(4, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 1, -1);
            run_instr(5, 4'b1100, 1'b0, 1'b0, 1'b0, 0, 1, -1);
            run_instr(6, 4'b0100, 1'b0, 1'b0, 1'b1, 0, 1, -1);
            run_instr(7, 4'b0100, 1'b0, 1'b0, 1'b0, 0, 1, -1);
            run_instr(8, 4'b0111, 1'b0, 1'b0, 1'b0, 0, 1, -1);
            run_instr(9, 4'b0110, 1'b0, 1'b0, 1'b0, 0, 1, -1);
            run_instr(10, 4'b1101, 1'b0, 1'b0, 1'b0, 3, 5, -1);
            run_instr(11, 4'b1010, 1'b0, 1'b0, 1'b0, 0, 1, -1);
            // LDR: reset lands during the second Mem_OE cycle of LDR1.
            run_instr(12, 4'b0110, 1'b0, 1'b0, 1'b0, 0, 1, ((ph != 0) ? 3 : 2) + 5);
            for (int i = 13; i < 170; i++)
                run_instr(i, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                          1'($urandom), $urandom_range(0, 3), $urandom_range(1, 5), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
